stepper_accel_ctrl: RTL and testbench
=====================================

# stepper_accel_ctrl

Avalon-MM-configured trapezoidal-profile step/direction generator for one Fisnar axis motor. Software loads step count, start interval, minimum interval and per-step interval delta over the HPS lightweight bridge. The block then sequences accelerate, cruise and decelerate phases, producing step pulses and a completion interrupt. It replaces software-timed stepping driven through the accelstep PIO registers.

## Interface

**Parameters**
- IW, 24, width of interval registers and counters (clocks per step).
- PULSE_W, 16, step pulse high time in clocks; minimum effective interval is 2*PULSE_W.

**Ports**
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- address, in, 3: register select.
- chipselect, in, 1: Avalon slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: combinational read mux; unmapped addresses read 0.
- step, out, 1: step pulse to driver.
- dir, out, 1: direction, latched at start.
- busy, out, 1: motion in progress.
- irq, out, 1: level interrupt; equals done AND irq_en.

## Operation

**Register map (32-bit words)**
- 0 CTRL/STATUS
  - Write: bit0 start, bit1 abort, bit2 dir, bit3 irq_en.
  - Read: bit0 busy, bit1 done (sticky), bit2 aborted (sticky), bits[5:3] state, bit6 irq_en.
- 1 STEPS: target step count, 32-bit.
- 2 INT_START: start/stop interval, IW bits.
- 3 INT_MIN: cruise interval, IW bits.
- 4 DELTA: interval change per step, IW bits.
- 5 POSITION: steps issued in current/last move. Read-only.

**Effective values, captured at start**
- i_start = max(INT_START, 2*PULSE_W).
- i_min = clamp(INT_MIN, 2*PULSE_W, i_start).
- All interval arithmetic is unsigned IW bits, saturating at i_min and i_start.

**States**
- IDLE (0), ACCEL (1), CRUISE (2), DECEL (3).

**Start** (write CTRL with start=1 in IDLE)
- Clears done and aborted; POSITION=0; ramp=0; interval=i_start; dir latched.
- STEPS=0: done=1, stay IDLE, no pulse.
- DELTA=0 or i_min==i_start: enter CRUISE.
- Otherwise: enter ACCEL.
- Start while busy is ignored; registers 1-4 may be rewritten while busy without affecting the move.

**Per step**
- Interval counter loads the current interval and counts down to 1, then the step fires.
- step is high for the first PULSE_W clocks of each interval. POSITION increments when the pulse rises. rem = STEPS - POSITION (new value).
- ACCEL: ramp++.
  - rem <= ramp: DECEL, interval = min(interval+DELTA, i_start).
  - Else: interval = max(interval-DELTA, i_min); if the result equals i_min, go to CRUISE.
- CRUISE: if rem <= ramp, go to DECEL with interval = min(interval+DELTA, i_start).
- DECEL: interval = min(interval+DELTA, i_start).
- Any state: rem == 0 returns to IDLE and sets done; this takes priority over all other updates.
- A short move switches ACCEL directly to DECEL (triangle profile, asymmetric by one step is acceptable).

**Abort** (write bit1 while busy)
- Next clock: IDLE, step=0 immediately (the pulse is truncated), aborted=1, done unchanged, POSITION frozen.
- Abort and start in the same write: abort wins, no move starts.

**Reset values**
- step=0, dir=0, busy=0, irq=0, readdata per the mux.
- All registers 0, state IDLE.

## Timing

- Write takes effect on the clock edge where chipselect & ~write_n.
- busy goes high on the next edge.
- First step rises exactly i_start clocks after the start-write edge.
- Rising-edge spacing of step n to step n+1 equals the interval computed at step n.
- done, busy=0 and irq update on the edge where the last pulse rises; the last pulse still completes its PULSE_W high time.
- Reads have zero wait states (combinational readdata).

## Test plan

- PULSE_W=4; STEPS=10, INT_START=100, INT_MIN=40, DELTA=20, start → step rising-edge spacings 100,80,60,40,40,40,40,60,80,100; POSITION=10, done=1, busy=0.
- STEPS=4, INT_START=100, INT_MIN=10, DELTA=20 → spacings 100,80,100,100; state sequence ACCEL→DECEL→IDLE.
- STEPS=0 with irq_en=1, start → no pulse; done=1 and irq=1 one clock after the write; new start clears irq.
- Abort write during step 5 high time → step low next clock, POSITION=5, aborted=1, done=0; a start in the same write as abort is ignored.
- INT_START=3, INT_MIN=1, DELTA=0, PULSE_W=4, STEPS=3 → constant spacing 8, state CRUISE; start rewritten mid-move has no effect.
- Assert reset_n low mid-move → step, busy, irq go 0 asynchronously; all registers read 0 after release.

Source files
------------

// File: rtl/stepper_accel_ctrl.sv
// rtl/stepper_accel_ctrl.sv - trapezoidal-profile step/direction generator with Avalon-MM registers
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[2:0]          register select (0 CTRL/STATUS, 1 STEPS, 2 INT_START,
//                         3 INT_MIN, 4 DELTA, 5 POSITION)
//   chipselect, write_n   Avalon write qualifier (write when chipselect & ~write_n)
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read mux, unmapped addresses read 0
//   step, dir             step pulse and direction to the motor driver
//   busy                  motion in progress
//   irq                   level interrupt, done & irq_en
module stepper_accel_ctrl #(
    parameter int IW      = 24,
    parameter int PULSE_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEL = 2'd1, CRUISE = 2'd2, DECEL = 2'd3} state_t;

    localparam logic [IW-1:0] MIN_INT = IW'(2 * PULSE_W);
    localparam logic [15:0]   PW_LAST = 16'(PULSE_W - 1);

    state_t        state, state_nxt;
    logic [31:0]   steps_reg, steps_cap, position, ramp, ramp_nxt;
    logic [IW-1:0] int_start_reg, int_min_reg, delta_reg;
    logic [IW-1:0] i_start, i_min, delta_cap, interval, interval_nxt, cnt;
    logic [15:0]   pulse_cnt;
    logic          irq_en, done, aborted;

    logic          wr_ctrl, do_start, do_abort, fire;
    logic [IW-1:0] s_eff, m_eff, int_up, int_dn;
    logic [IW:0]   up_sum;
    logic [31:0]   pos_inc, rem, ramp_inc;

    assign busy = (state != IDLE);
    assign irq  = done & irq_en;

    always_comb begin
        wr_ctrl  = chipselect & ~write_n & (address == 3'd0);
        // Abort has priority over start in the same write; start only from idle.
        do_abort = wr_ctrl & writedata[1] & busy;
        do_start = wr_ctrl & writedata[0] & ~writedata[1] & ~busy;
        fire     = busy & (cnt == IW'(1));

        // Effective intervals derived from the live registers, captured on start.
        s_eff = (int_start_reg < MIN_INT) ? MIN_INT : int_start_reg;
        if (int_min_reg < MIN_INT)
            m_eff = MIN_INT;
        else if (int_min_reg > s_eff)
            m_eff = s_eff;
        else
            m_eff = int_min_reg;

        pos_inc  = position + 32'd1;
        rem      = steps_cap - pos_inc;
        ramp_inc = ramp + 32'd1;

        // Saturating interval steps; interval always lies within [i_min, i_start].
        up_sum = {1'b0, interval} + {1'b0, delta_cap};
        int_up = (up_sum >= {1'b0, i_start}) ? i_start : up_sum[IW-1:0];
        int_dn = (delta_cap >= interval - i_min) ? i_min : interval - delta_cap;
    end

    always_comb begin
        state_nxt    = state;
        interval_nxt = interval;
        ramp_nxt     = ramp;
        if (do_abort) begin
            state_nxt = IDLE;
        end else if (do_start) begin
            interval_nxt = s_eff;
            ramp_nxt     = 32'd0;
            if (steps_reg == 32'd0)
                state_nxt = IDLE;
            else if (delta_reg == '0 || m_eff == s_eff)
                state_nxt = CRUISE;
            else
                state_nxt = ACCEL;
        end else if (fire) begin
            if (rem == 32'd0) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    ACCEL: begin
                        ramp_nxt = ramp_inc;
                        if (rem <= ramp_inc) begin
                            state_nxt    = DECEL;
                            interval_nxt = int_up;
                        end else begin
                            interval_nxt = int_dn;
                            if (int_dn == i_min)
                                state_nxt = CRUISE;
                        end
                    end
                    CRUISE: begin
                        if (rem <= ramp) begin
                            state_nxt    = DECEL;
                            interval_nxt = int_up;
                        end
                    end
                    DECEL:   interval_nxt = int_up;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            interval      <= '0;
            ramp          <= '0;
            steps_reg     <= '0;
            int_start_reg <= '0;
            int_min_reg   <= '0;
            delta_reg     <= '0;
            steps_cap     <= '0;
            i_start       <= '0;
            i_min         <= '0;
            delta_cap     <= '0;
            cnt           <= '0;
            position      <= '0;
            pulse_cnt     <= '0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            dir           <= 1'b0;
            step          <= 1'b0;
        end else begin
            state    <= state_nxt;
            interval <= interval_nxt;
            ramp     <= ramp_nxt;

            if (chipselect && !write_n) begin
                case (address)
                    3'd0:    irq_en        <= writedata[3];
                    3'd1:    steps_reg     <= writedata;
                    3'd2:    int_start_reg <= writedata[IW-1:0];
                    3'd3:    int_min_reg   <= writedata[IW-1:0];
                    3'd4:    delta_reg     <= writedata[IW-1:0];
                    default: ;
                endcase
            end

            if (do_abort) begin
                aborted <= 1'b1;
            end else if (do_start) begin
                steps_cap <= steps_reg;
                i_start   <= s_eff;
                i_min     <= m_eff;
                delta_cap <= delta_reg;
                cnt       <= s_eff;
                position  <= 32'd0;
                dir       <= writedata[2];
                aborted   <= 1'b0;
                done      <= (steps_reg == 32'd0);
            end else if (fire) begin
                position <= pos_inc;
                cnt      <= interval_nxt;
                if (rem == 32'd0)
                    done <= 1'b1;
            end else if (busy) begin
                cnt <= cnt - IW'(1);
            end

            // The pulse timer runs independently of the state so the final
            // pulse completes after the move has returned to idle.
            if (do_abort) begin
                step <= 1'b0;
            end else if (fire) begin
                step      <= 1'b1;
                pulse_cnt <= PW_LAST;
            end else if (step) begin
                if (pulse_cnt == 16'd0)
                    step <= 1'b0;
                else
                    pulse_cnt <= pulse_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = {25'd0, irq_en, 1'b0, state, aborted, done, busy};
            3'd1:    readdata = steps_reg;
            3'd2:    readdata = 32'(int_start_reg);
            3'd3:    readdata = 32'(int_min_reg);
            3'd4:    readdata = 32'(delta_reg);
            3'd5:    readdata = position;
            default: readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_stepper_accel_ctrl.sv
// tb/tb_stepper_accel_ctrl.sv - self-checking bench for stepper_accel_ctrl
module tb_stepper_accel_ctrl;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        step, dir, busy, irq;

    int n_checks = 0;
    int n_fail = 0;

    int cyc = 0;
    logic step_prev = 1'b0;
    int rises[$];
    int st_q[$];
    int unsigned exp_sp[$];
    int unsigned exp_st[$];
    int start_ref;

    stepper_accel_ctrl #(.IW(24), .PULSE_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .step(step), .dir(dir), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    // Rising edges of step are timestamped in negedge counts; state is only
    // sampled when the bus is parked on address 0.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (step && !step_prev) begin
            rises.push_back(cyc);
            if (address == 3'd0 && !chipselect)
                st_q.push_back(int'(readdata[5:3]));
            else
                st_q.push_back(7);
        end
        step_prev = step;
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        address = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference profile: plain sequential arithmetic over the move rules.
    task automatic model(input int unsigned steps, input int unsigned is,
                         input int unsigned im, input int unsigned d);
        longint s, m, iv, ramp, rem;
        int ph;
        exp_sp.delete(); exp_st.delete();
        s = (is < 2 * PW) ? 2 * PW : is;
        m = (im < 2 * PW) ? 2 * PW : ((im > s) ? s : im);
        if (steps == 0) return;
        ph = (d == 0 || m == s) ? 2 : 1;
        iv = s; ramp = 0;
        exp_sp.push_back(int'(s));
        for (int n = 1; n <= int'(steps); n++) begin
            rem = longint'(steps) - n;
            if (rem == 0) begin
                exp_st.push_back(0);
                break;
            end
            if (ph == 1) begin
                ramp++;
                if (rem <= ramp) begin
                    ph = 3;
                    iv = (iv + d > s) ? s : iv + d;
                end else begin
                    iv = (iv - m <= d) ? m : iv - d;
                    if (iv == m) ph = 2;
                end
            end else if (ph == 2) begin
                if (rem <= ramp) begin
                    ph = 3;
                    iv = (iv + d > s) ? s : iv + d;
                end
            end else begin
                iv = (iv + d > s) ? s : iv + d;
            end
            exp_sp.push_back(int'(iv));
            exp_st.push_back(ph);
        end
    endtask

    task automatic start_move(input int unsigned steps, input int unsigned is,
                              input int unsigned im, input int unsigned d,
                              input logic irqen, input logic dirb);
        wr(3'd1, steps);
        wr(3'd2, is);
        wr(3'd3, im);
        wr(3'd4, d);
        rises.delete(); st_q.delete();
        wr(3'd0, {28'd0, irqen, dirb, 2'b01});
        start_ref = cyc + 1;
    endtask

    task automatic verify_move(input string name, input int unsigned steps, input logic dirb);
        logic [31:0] r;
        int t, k;
        k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b required 0", name, busy);
        end
        repeat (2 * PW + 4) @(negedge clk);
        n_checks++;
        if (rises.size() != exp_sp.size()) begin
            n_fail++;
            $display("FAIL %s_pulse_count: got %0d required %0d", name, rises.size(), exp_sp.size());
        end
        t = start_ref;
        for (int i = 0; i < exp_sp.size() && i < rises.size(); i++) begin
            t = t + int'(exp_sp[i]);
            n_checks++;
            if (rises[i] != t) begin
                n_fail++;
                $display("FAIL %s_rise%0d: at %0d required %0d", name, i, rises[i], t);
            end
            if (i < exp_st.size() && st_q[i] != 7) begin
                n_checks++;
                if (st_q[i] != int'(exp_st[i])) begin
                    n_fail++;
                    $display("FAIL %s_state%0d: got %0d required %0d", name, i, st_q[i], exp_st[i]);
                end
            end
        end
        rd(3'd5, r);
        n_checks++;
        if (r !== steps) begin
            n_fail++;
            $display("FAIL %s_position: got %0d required %0d", name, r, steps);
        end
        rd(3'd0, r);
        n_checks++;
        if (r[2:0] !== 3'b010 || step !== 1'b0 || dir !== dirb) begin
            n_fail++;
            $display("FAIL %s_final: status=%0h step=%0b dir=%0b required status[2:0]=2 step=0 dir=%0b",
                     name, r, step, dir, dirb);
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        n_checks++;
        if (step !== 1'b0 || busy !== 1'b0 || irq !== 1'b0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: step=%0b busy=%0b irq=%0b dir=%0b required 0", step, busy, irq, dir);
        end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r);
            n_checks++;
            if (r !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %0h required 0", a, r);
            end
        end
    endtask

    task automatic test_trapezoid;
        exp_sp = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
        exp_st = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 0};
        start_move(10, 100, 40, 20, 1'b0, 1'b1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_busy: got %0b required 1", busy);
        end
        verify_move("trap", 10, 1'b1);
    endtask

    task automatic test_triangle;
        exp_sp = '{100, 80, 100, 100};
        exp_st = '{1, 3, 3, 0};
        start_move(4, 100, 10, 20, 1'b0, 1'b0);
        verify_move("tri", 4, 1'b0);
    endtask

    task automatic test_zero_steps;
        logic [31:0] r;
        start_move(0, 100, 40, 20, 1'b1, 1'b0);
        rd(3'd0, r);
        n_checks++;
        if (r[1] !== 1'b1 || irq !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%0b irq=%0b busy=%0b required 1 1 0", r[1], irq, busy);
        end
        idle(50);
        n_checks++;
        if (rises.size() != 0) begin
            n_fail++;
            $display("FAIL zero_nopulse: got %0d pulses required 0", rises.size());
        end
        model(3, 20, 10, 4);
        start_move(3, 20, 10, 4, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_irq_clear: irq=%0b busy=%0b required 0 1", irq, busy);
        end
        verify_move("zero_next", 3, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_irq_end: got %0b required 1", irq);
        end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        int k;
        start_move(10, 100, 40, 20, 1'b0, 1'b0);
        k = 0;
        while (rises.size() < 5 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (rises.size() < 5 || step !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach5: pulses=%0d step=%0b required 5 1", rises.size(), step);
        end
        wr(3'd0, 32'h3);
        n_checks++;
        if (step !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: step=%0b busy=%0b required 0 0", step, busy);
        end
        rd(3'd5, r);
        n_checks++;
        if (r !== 32'd5) begin
            n_fail++;
            $display("FAIL abort_position: got %0d required 5", r);
        end
        rd(3'd0, r);
        n_checks++;
        if (r[2:0] !== 3'b100 || r[5:3] !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_status: got %0h required aborted=1 done=0 busy=0 idle", r);
        end
        idle(200);
        n_checks++;
        if (rises.size() != 5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nostart: pulses=%0d busy=%0b required 5 0", rises.size(), busy);
        end
    endtask

    task automatic test_cruise_const;
        int k;
        exp_sp = '{8, 8, 8};
        exp_st = '{2, 2, 0};
        start_move(3, 3, 1, 0, 1'b0, 1'b1);
        k = 0;
        while (rises.size() < 1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        wr(3'd1, 20);
        wr(3'd2, 50);
        wr(3'd0, 32'h1);
        verify_move("cruise", 3, 1'b1);
    endtask

    task automatic test_random;
        int unsigned s, is, im, d;
        logic db;
        for (int n = 0; n < 6; n++) begin
            s  = $urandom_range(1, 12);
            is = $urandom_range(4, 80);
            im = $urandom_range(1, 90);
            d  = $urandom_range(0, 30);
            db = 1'($urandom_range(0, 1));
            model(s, is, im, d);
            start_move(s, is, im, d, 1'b0, db);
            verify_move($sformatf("rand%0d", n), s, db);
        end
    endtask

    task automatic test_reset_mid_move;
        logic [31:0] r;
        int k;
        start_move(10, 60, 20, 10, 1'b1, 1'b1);
        k = 0;
        while (rises.size() < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (step !== 1'b0 || busy !== 1'b0 || irq !== 1'b0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: step=%0b busy=%0b irq=%0b dir=%0b required 0", step, busy, irq, dir);
        end
        idle(3);
        reset_n = 1'b1;
        idle(2);
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), r);
            n_checks++;
            if (r !== 32'd0) begin
                n_fail++;
                $display("FAIL post_reset_reg%0d: got %0h required 0", a, r);
            end
        end
    endtask

    initial begin
        idle(4);
        reset_n = 1'b1;
        idle(2);
        test_reset();
        test_trapezoid();
        test_triangle();
        test_zero_steps();
        test_abort();
        test_cruise_const();
        test_random();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
